// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multi-cycle RV64I controller: FSM states, opcodes,
// ALU operation encodings and the instruction class latched in DECODE.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_ILL = 3'd5
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] opc);
    case (opc)
      OPC_R:   return CLS_R;
      OPC_I:   return CLS_I;
      OPC_LD:  return CLS_LD;
      OPC_ST:  return CLS_ST;
      OPC_BR:  return CLS_BR;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles spent without mem_ready; expired flags the last cycle
// the controller may still wait before it must give up.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the RV64I datapath: one FETCH..WB pass per
// instruction, memory handshake with timeout, sticky trap and retire counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_e       state_q, state_d;
  instr_class_e cls_q;
  logic         timer_clear, timer_en, timer_expired;

  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_mem_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      FETCH: begin
        if (halt_req) begin
          state_d = HALT;
        end else begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end
      end

      DECODE: state_d = (classify(opcode) == CLS_ILL) ? TRAP : EXEC;

      EXEC: begin
        case (cls_q)
          CLS_R: begin
            alu_op  = ALU_RTYPE;
            state_d = WB;
          end
          CLS_I: begin
            alu_src = 1'b1;
            alu_op  = ALU_ITYPE;
            state_d = WB;
          end
          CLS_LD, CLS_ST: begin
            alu_src     = 1'b1;
            alu_op      = ALU_ADD;
            timer_clear = 1'b1;
            state_d     = MEM;
          end
          CLS_BR: begin
            alu_op   = ALU_BRANCH;
            pc_write = 1'b1;
            pc_src   = branch_taken;
            state_d  = FETCH;
          end
          default: state_d = TRAP;
        endcase
      end

      MEM: begin
        alu_src   = 1'b1;
        alu_op    = ALU_ADD;
        mem_read  = (cls_q == CLS_LD);
        mem_write = (cls_q == CLS_ST);
        if (mem_ready) begin
          if (cls_q == CLS_ST) begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d  = WB;
          end
        end else if (timer_expired) begin
          // Give up without write-back; the memory never answered.
          state_d = TRAP;
        end else begin
          timer_en = 1'b1;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LD);
        pc_write   = 1'b1;
        state_d    = FETCH;
      end

      HALT: if (!halt_req) state_d = FETCH;

      TRAP: state_d = TRAP;

      default: state_d = TRAP;
    endcase

    // An instruction interrupted by reset must not commit anything.
    if (reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      trap    <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      trap    <= trap | (state_d == TRAP);
      if (pc_write) retired <= retired + CNT_W'(1);
    end
  end

  // NOTE: the class latch has no reset; it is always rewritten in DECODE
  // before EXEC, MEM or WB can read it.
  always_ff @(posedge clk) begin
    if (state_q == DECODE) cls_q <= classify(opcode);
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each driven cycle pushes its expected control vector
// and retire count; a negedge monitor pops and compares them.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  localparam int MEM_WAIT_MAX = 16;
  localparam int CNT_W        = 4;

  logic             clk = 1'b0;
  logic             reset, branch_taken, mem_ready, halt_req;
  logic [6:0]       opcode;
  logic             ir_write, pc_write, pc_src, alu_src;
  logic [1:0]       alu_op;
  logic             mem_read, mem_write, mem_to_reg, reg_write, trap;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [13:0]      obs_ctl;

  multicycle_controller #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .halt_req(halt_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .state(state), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs_ctl = {ir_write, pc_write, pc_src, alu_src, alu_op, mem_read,
                    mem_write, mem_to_reg, reg_write, trap, state};

  typedef struct {
    string            tag;
    logic [13:0]      ctl;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_ret  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic ir, pcw, pcs, as,
                                     input logic [1:0] aop,
                                     input logic mr, mw, m2r, rw, tr,
                                     input state_e st);
    return {ir, pcw, pcs, as, aop, mr, mw, m2r, rw, tr, st};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, "/ctl"}, 32'(obs_ctl), 32'(mon_e.ctl));
      check({mon_e.tag, "/retired"}, 32'(retired), 32'(mon_e.ret));
    end
  end

  // Drive one cycle of inputs and queue what that cycle must show.
  task automatic cyc(input string tag, input logic rst, ht, bt, mr, input logic [13:0] ctl);
    reset = rst; halt_req = ht; branch_taken = bt; mem_ready = mr;
    sb.push_back('{tag: tag, ctl: ctl, ret: exp_ret});
    @(posedge clk); #1;
  endtask

  function automatic logic [13:0] v_fetch();
    return mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, FETCH);
  endfunction
  function automatic logic [13:0] v_decode();
    return mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, DECODE);
  endfunction

  task automatic run_alu(input string n, input logic [6:0] opc, input logic as,
                         input logic [1:0] aop, input logic noise);
    opcode = opc;
    cyc({n, "/F"}, 0, 0, noise, noise, v_fetch());
    cyc({n, "/D"}, 0, 0, noise, noise, v_decode());
    cyc({n, "/E"}, 0, 0, noise, noise, mk(0, 0, 0, as, aop, 0, 0, 0, 0, 0, EXEC));
    cyc({n, "/W"}, 0, 0, noise, noise, mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, WB));
    exp_ret++;
  endtask

  task automatic run_ld(input string n, input int waits);
    opcode = OPC_LD;
    cyc({n, "/F"}, 0, 0, 0, 0, v_fetch());
    cyc({n, "/D"}, 0, 0, 0, 0, v_decode());
    cyc({n, "/E"}, 0, 0, 0, 0, mk(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, EXEC));
    for (int i = 0; i < waits; i++)
      cyc($sformatf("%s/Mw%0d", n, i), 0, 0, 0, 0, mk(0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, MEM));
    cyc({n, "/Mr"}, 0, 0, 0, 1, mk(0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, MEM));
    cyc({n, "/W"}, 0, 0, 0, 0, mk(0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0, WB));
    exp_ret++;
  endtask

  task automatic run_st(input string n, input int waits);
    opcode = OPC_ST;
    cyc({n, "/F"}, 0, 0, 0, 0, v_fetch());
    cyc({n, "/D"}, 0, 0, 0, 0, v_decode());
    cyc({n, "/E"}, 0, 0, 0, 0, mk(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, EXEC));
    for (int i = 0; i < waits; i++)
      cyc($sformatf("%s/Mw%0d", n, i), 0, 0, 0, 0, mk(0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, MEM));
    cyc({n, "/Mr"}, 0, 0, 0, 1, mk(0, 1, 0, 1, 2'b00, 0, 1, 0, 0, 0, MEM));
    exp_ret++;
  endtask

  task automatic run_br(input string n, input logic bt);
    opcode = OPC_BR;
    cyc({n, "/F"}, 0, 0, 0, 1, v_fetch());
    cyc({n, "/D"}, 0, 0, 0, 1, v_decode());
    cyc({n, "/E"}, 0, 0, bt, 1, mk(0, 1, bt, 0, 2'b01, 0, 0, 0, 0, 0, EXEC));
    exp_ret++;
  endtask

  initial begin
    reset = 1'b1; halt_req = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    opcode = 7'd0;
    @(posedge clk); #1;
    cyc("reset", 1, 0, 0, 0, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, FETCH));

    run_alu("add", OPC_R, 1'b0, 2'b10, 1'b0);
    run_alu("addi_noise", OPC_I, 1'b1, 2'b11, 1'b1);
    run_ld("ld_w2", 2);
    run_ld("ld_w0", 0);
    run_st("sd_w0", 0);
    run_st("sd_w1", 1);
    run_br("beq_t", 1'b1);
    run_br("beq_nt", 1'b0);

    cyc("halt/F", 0, 1, 0, 0, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, FETCH));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("halt/H%0d", i), 0, 1, 1, 1, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, HALT));
    cyc("halt/rel", 0, 0, 1, 1, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, HALT));
    run_alu("add_after_halt", OPC_R, 1'b0, 2'b10, 1'b0);

    // Reset during WB: nothing commits and the retire count restarts.
    opcode = OPC_R;
    cyc("mid/F", 0, 0, 0, 0, v_fetch());
    cyc("mid/D", 0, 0, 0, 0, v_decode());
    cyc("mid/E", 0, 0, 0, 0, mk(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, EXEC));
    cyc("mid/rst", 1, 0, 0, 0, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, WB));
    exp_ret = '0;

    for (int i = 0; i < 16; i++) run_br($sformatf("wrap%0d", i), 1'b0);
    run_alu("add_post_wrap", OPC_R, 1'b0, 2'b10, 1'b0);

    opcode = 7'b1111111;
    cyc("ill/F", 0, 0, 0, 0, v_fetch());
    cyc("ill/D", 0, 0, 0, 0, v_decode());
    cyc("ill/T0", 0, 0, 0, 1, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, TRAP));
    cyc("ill/T1", 0, 1, 1, 1, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, TRAP));
    cyc("ill/rst", 1, 0, 0, 0, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, TRAP));
    exp_ret = '0;
    run_alu("add_after_trap", OPC_R, 1'b0, 2'b10, 1'b0);

    opcode = OPC_ST;
    cyc("tmo/F", 0, 0, 0, 0, v_fetch());
    cyc("tmo/D", 0, 0, 0, 0, v_decode());
    cyc("tmo/E", 0, 0, 0, 0, mk(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, EXEC));
    for (int i = 0; i < MEM_WAIT_MAX; i++)
      cyc($sformatf("tmo/M%0d", i), 0, 0, 0, 0, mk(0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, MEM));
    for (int i = 0; i < 3; i++)
      cyc($sformatf("tmo/T%0d", i), 0, 0, 0, 1, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, TRAP));
    cyc("tmo/rst", 1, 0, 0, 0, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, TRAP));
    exp_ret = '0;
    cyc("tmo/F_after", 0, 0, 0, 0, v_fetch());

    reset = 1'b0;
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) check("drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
